// File: rtl/ls1u_bus_pkg.sv
// Shared LS1u peripheral-bus definitions: initiator FSM encoding, error read
// value and default timeout used by the byte-wide Wishbone master.
package ls1u_bus_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CYCLE = 1'b1
   } wb_state_e;

   localparam logic [7:0] WB_ERR_RDATA       = 8'hFF;
   localparam int         WB_TIMEOUT_DEFAULT = 15;

   // A zero timeout still needs a one-bit counter so the ports stay legal.
   function automatic int wb_cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_byte_master_if.sv
// Byte-wide classic Wishbone bus between the LS1u initiator and its responders.
interface wb_byte_master_if #(
   parameter int ADDR_WIDTH = 24
) ();

   logic [ADDR_WIDTH-1:0] WB_ADRo;
   logic [7:0]            WB_DATo;
   logic [7:0]            WB_DATi;
   logic                  WB_WEo;
   logic                  WB_CYCo;
   logic                  WB_STBo;
   logic                  WB_ACKi;

   modport master (
      output WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo,
      input  WB_DATi, WB_ACKi
   );

   modport slave (
      input  WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo,
      output WB_DATi, WB_ACKi
   );

endinterface

// File: rtl/wb_byte_master_timeout_cnt.sv
// Saturating wait-cycle counter; expired flags the last cycle CYC may stay high.
module wb_timeout_cnt import ls1u_bus_pkg::*; #(
   parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int             CW     = wb_cnt_width(TIMEOUT);
   localparam bit             HAS_TO = (TIMEOUT != 0);
   localparam logic [CW-1:0]  SAT    = CW'(TIMEOUT);
   localparam logic [CW-1:0]  TC     = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // With TIMEOUT = 0 the counter is pinned at zero and never expires.
   assign expired = HAS_TO && (cnt == TC);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-wide Wishbone initiator for the LS1u load/store port: one CPU access
// runs exactly one classic cycle, aborted with an error if the slave hangs.
//
// state    | meaning
// ST_IDLE  | bus released, waiting for cpu_req
// ST_CYCLE | CYC/STB asserted, waiting for ACK or timeout
module wb_byte_master import ls1u_bus_pkg::*; #(
   parameter int ADDR_WIDTH = 24,
   parameter int TIMEOUT    = WB_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [7:0]            cpu_wdata,
   output logic                  cpu_busy,
   output logic                  cpu_done,
   output logic                  cpu_err,
   output logic [7:0]            cpu_rdata,
   wb_byte_master_if.master      wb
);

   wb_state_e             state;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [7:0]            dat_q;
   logic                  we_q;
   logic                  cyc_q;
   logic                  to_clr;
   logic                  to_en;
   logic                  to_expired;

   assign to_clr = (state == ST_IDLE);
   assign to_en  = (state == ST_CYCLE) && !wb.WB_ACKi;

   wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         cyc_q     <= 1'b0;
         cpu_busy  <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  adr_q    <= cpu_addr;
                  dat_q    <= cpu_wdata;
                  we_q     <= cpu_we;
                  cyc_q    <= 1'b1;
                  cpu_busy <= 1'b1;
                  state    <= ST_CYCLE;
               end
            end
            ST_CYCLE: begin
               // ACK is tested first so a late ACK on the final cycle still wins.
               if (wb.WB_ACKi) begin
                  if (!we_q) begin
                     cpu_rdata <= wb.WB_DATi;
                  end
                  cyc_q    <= 1'b0;
                  we_q     <= 1'b0;
                  cpu_busy <= 1'b0;
                  cpu_done <= 1'b1;
                  state    <= ST_IDLE;
               end else if (to_expired) begin
                  if (!we_q) begin
                     cpu_rdata <= WB_ERR_RDATA;
                  end
                  cyc_q    <= 1'b0;
                  we_q     <= 1'b0;
                  cpu_busy <= 1'b0;
                  cpu_done <= 1'b1;
                  cpu_err  <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign wb.WB_ADRo = adr_q;
   assign wb.WB_DATo = dat_q;
   assign wb.WB_WEo  = we_q;
   assign wb.WB_CYCo = cyc_q;
   assign wb.WB_STBo = cyc_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Randomized bench for wb_byte_master: a scripted-latency slave plus a
// transaction-level model of expected bus length, error and read data.
module tb_wb_byte_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [23:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        sel = 1'b0;

   logic        busy0, done0, err0, busy1, done1, err1;
   logic [7:0]  rdata0, rdata1;

   int          slv_wait = 0;
   bit          slv_never = 1'b0;
   logic [7:0]  slv_rd = '0;
   int          age0, age1;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  exp_rd [2];

   wb_byte_master_if #(.ADDR_WIDTH(24)) w0 ();
   wb_byte_master_if #(.ADDR_WIDTH(24)) w1 ();

   wb_byte_master #(.ADDR_WIDTH(24), .TIMEOUT(15)) u_dut0 (
      .clk(clk), .rst(rst), .cpu_req(cpu_req && !sel), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(busy0),
      .cpu_done(done0), .cpu_err(err0), .cpu_rdata(rdata0), .wb(w0.master)
   );

   wb_byte_master #(.ADDR_WIDTH(24), .TIMEOUT(0)) u_dut1 (
      .clk(clk), .rst(rst), .cpu_req(cpu_req && sel), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(busy1),
      .cpu_done(done1), .cpu_err(err1), .cpu_rdata(rdata1), .wb(w1.master)
   );

   always #5 clk = ~clk;

   // Slave: ACK during the (slv_wait+1)-th cycle of CYC, unless it never answers.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         age0 <= 0;
         age1 <= 0;
      end else begin
         age0 <= w0.WB_CYCo ? age0 + 1 : 0;
         age1 <= w1.WB_CYCo ? age1 + 1 : 0;
      end
   end
   assign w0.WB_ACKi = w0.WB_CYCo && !slv_never && (age0 == slv_wait);
   assign w1.WB_ACKi = w1.WB_CYCo && !slv_never && (age1 == slv_wait);
   assign w0.WB_DATi = slv_rd;
   assign w1.WB_DATi = slv_rd;

   logic        obs_cyc, obs_stb, obs_we, obs_busy, obs_done, obs_err;
   logic [23:0] obs_adr;
   logic [7:0]  obs_dat, obs_rdata;
   assign obs_cyc   = sel ? w1.WB_CYCo : w0.WB_CYCo;
   assign obs_stb   = sel ? w1.WB_STBo : w0.WB_STBo;
   assign obs_we    = sel ? w1.WB_WEo  : w0.WB_WEo;
   assign obs_adr   = sel ? w1.WB_ADRo : w0.WB_ADRo;
   assign obs_dat   = sel ? w1.WB_DATo : w0.WB_DATo;
   assign obs_busy  = sel ? busy1 : busy0;
   assign obs_done  = sel ? done1 : done0;
   assign obs_err   = sel ? err1  : err0;
   assign obs_rdata = sel ? rdata1 : rdata0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge with the DUT idle (or in a done cycle); returns in the done cycle.
   task automatic run_access(input bit we, input logic [23:0] addr, input logic [7:0] wd,
                             input int wait_n, input bit never, input logic [7:0] rd,
                             input bit keep_req, input int to);
      int cyc_n = 0;
      int done_n = 0;
      int stb_bad = 0;
      int busy_bad = 0;
      bit exp_err;
      int exp_cyc;
      exp_err = never || (to > 0 && wait_n >= to);
      exp_cyc = exp_err ? to : wait_n + 1;
      if (!we) exp_rd[sel] = exp_err ? 8'hFF : rd;
      slv_wait = wait_n; slv_never = never; slv_rd = rd;
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
      for (int i = 0; i < 400 && done_n == 0; i++) begin
         @(negedge clk);
         if (!keep_req) cpu_req = 1'b0;
         if (i == 0) begin
            check_eq("accept_cyc", obs_cyc, 1);
            check_eq("accept_done_low", obs_done, 0);
            check_eq("bus_adr", obs_adr, addr);
            check_eq("bus_we", obs_we, we);
            if (we) check_eq("bus_dat", obs_dat, wd);
         end
         if (obs_stb !== obs_cyc) stb_bad++;
         if (obs_busy !== obs_cyc) busy_bad++;
         if (obs_cyc) cyc_n++;
         if (obs_done) begin
            done_n++;
            check_eq("done_cyc_low", obs_cyc, 0);
            check_eq("done_err", obs_err, exp_err);
            check_eq("done_rdata", obs_rdata, exp_rd[sel]);
            check_eq("cyc_length", cyc_n, exp_cyc);
         end
      end
      check_eq("done_seen", done_n, 1);
      check_eq("stb_eq_cyc", stb_bad, 0);
      check_eq("busy_eq_cyc", busy_bad, 0);
   endtask

   initial begin
      int done_n;
      bit keep;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_cyc", obs_cyc, 0);
      check_eq("rst_stb", obs_stb, 0);
      check_eq("rst_we", obs_we, 0);
      check_eq("rst_busy", obs_busy, 0);
      check_eq("rst_done", obs_done, 0);
      check_eq("rst_err", obs_err, 0);
      check_eq("rst_adr", obs_adr, 0);
      check_eq("rst_dat", obs_dat, 0);
      check_eq("rst_rdata", obs_rdata, 0);
      rst = 1'b1;
      @(negedge clk);

      run_access(1'b1, 24'h000000, 8'h81, 0, 1'b0, 8'h00, 1'b0, 15);
      run_access(1'b0, 24'h000000, 8'h00, 0, 1'b0, 8'h05, 1'b0, 15);
      run_access(1'b0, 24'h000010, 8'h00, 3, 1'b0, 8'h5A, 1'b1, 15);
      run_access(1'b1, 24'h123456, 8'hC3, 0, 1'b0, 8'h00, 1'b0, 15);
      run_access(1'b0, 24'hABCDEF, 8'h00, 0, 1'b1, 8'h77, 1'b0, 15);
      run_access(1'b0, 24'h000020, 8'h00, 14, 1'b0, 8'h3C, 1'b0, 15);
      run_access(1'b0, 24'h000021, 8'h00, 15, 1'b0, 8'h3D, 1'b0, 15);
      run_access(1'b1, 24'h000022, 8'h11, 20, 1'b0, 8'h00, 1'b0, 15);
      @(negedge clk);

      // Reset during the third wait cycle of a read.
      slv_wait = 10; slv_never = 1'b0; slv_rd = 8'h99;
      cpu_we = 1'b0; cpu_addr = 24'h000300; cpu_req = 1'b1;
      @(negedge clk); cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("pre_rst_cyc", obs_cyc, 1);
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_cyc", obs_cyc, 0);
      check_eq("async_rst_stb", obs_stb, 0);
      check_eq("async_rst_busy", obs_busy, 0);
      done_n = 0;
      repeat (3) begin
         @(negedge clk);
         if (obs_done) done_n++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (obs_done) done_n++;
      check_eq("rst_no_done", done_n, 0);
      exp_rd[0] = 8'h00;
      check_eq("rst_rdata_clr", obs_rdata, 0);
      check_eq("rst_adr_clr", obs_adr, 0);
      run_access(1'b1, 24'h000400, 8'h42, 2, 1'b0, 8'h00, 1'b0, 15);

      // Randomized traffic, some chained back-to-back, some timing out.
      for (int n = 0; n < 40; n++) begin
         keep = ($urandom_range(0, 2) == 0);
         run_access(1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom),
                    int'($urandom_range(0, 18)), ($urandom_range(0, 7) == 0),
                    8'($urandom), keep, 15);
         if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      cpu_req = 1'b0;
      @(negedge clk);

      // TIMEOUT = 0 instance waits indefinitely for a late ACK.
      sel = 1'b1;
      @(negedge clk);
      run_access(1'b0, 24'h000500, 8'h00, 100, 1'b0, 8'hE7, 1'b0, 0);
      @(negedge clk);
      check_eq("to0_done_1cyc", obs_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_byte_master.md
# wb_byte_master

Byte-wide Wishbone initiator bridging the LS1u core's load/store port onto the peripheral bus, driving responders such as the interrupt controller, timers, UART and SPI. It accepts one CPU access at a time and runs exactly one classic Wishbone cycle for it. It returns read data or an error pulse to the core. A bounded timeout aborts cycles to absent or hung slaves so the core never stalls indefinitely.

## Interface
- `ADDR_WIDTH`, 24, width of CPU and Wishbone byte address (matches 24-bit vector/code space).
- `TIMEOUT`, 15, maximum cycles `WB_CYCo` stays high awaiting ACK; 0 disables timeout.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  access request (level); accepted only while `cpu_busy`=0.
- `cpu_we`  in  1  1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr`  in  ADDR_WIDTH  byte address; sampled on accept.
- `cpu_wdata`  in  8  write data; sampled on accept.
- `cpu_busy`  out  1  cycle in progress; registered.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  one-cycle pulse coincident with `cpu_done` on timeout.
- `cpu_rdata`  out  8  read data; valid with `cpu_done`, held until next read completes.
- `WB_ADRo`  out  ADDR_WIDTH  Wishbone address.
- `WB_DATo`  out  8  Wishbone write data.
- `WB_DATi`  in  8  Wishbone read data.
- `WB_WEo`  out  1  write enable.
- `WB_CYCo`  out  1  cycle valid.
- `WB_STBo`  out  1  strobe; always equal to `WB_CYCo`.
- `WB_ACKi`  in  1  slave acknowledge; may be combinational/constant high.

## Operation
- States: IDLE, CYCLE.
- IDLE: if `cpu_req`=1, latch `cpu_addr`/`cpu_wdata`/`cpu_we` into `WB_ADRo`/`WB_DATo`/`WB_WEo`, clear timeout counter, set `WB_CYCo`=`WB_STBo`=1, `cpu_busy`=1, go CYCLE.
- CYCLE, `WB_ACKi`=1: on read capture `WB_DATi` into `cpu_rdata`; on write `cpu_rdata` unchanged; drop CYC/STB/WE, `cpu_busy`=0, pulse `cpu_done`, go IDLE.
- CYCLE, no ACK: increment counter; when counter reaches `TIMEOUT`-1 and ACK still low, abort: drop CYC/STB/WE, pulse `cpu_done`+`cpu_err`, read returns `cpu_rdata`=8'hFF, go IDLE.
- ACK and timeout in same cycle: ACK wins, no error.
- `TIMEOUT`=0: counter never aborts; cycle waits for ACK forever.
- `cpu_req` while busy: ignored (not queued); core must hold it until `cpu_busy`=0.
- `WB_ADRo`/`WB_DATo` hold last values in IDLE; only CYC/STB/WE qualify the bus.
- Counter width = clog2(TIMEOUT+1), saturating; no wrap.

## Timing
- Reset (async assert): state IDLE; `WB_CYCo`,`WB_STBo`,`WB_WEo`,`cpu_busy`,`cpu_done`,`cpu_err` = 0; `WB_ADRo`=0, `WB_DATo`=0, `cpu_rdata`=0. Reset mid-cycle drops CYC/STB immediately; no `cpu_done` is issued for the aborted access.
- Accept at edge N → CYC/STB high during cycle N+1.
- ACK seen at edge N+k → `cpu_done` high and CYC low during cycle N+k+1. Zero-wait slave: done 2 cycles after accept.
- Back-to-back: a request present in the `cpu_done` cycle is accepted at that edge. Peak throughput is 1 access / 2 cycles.
- Timeout: CYC high for exactly `TIMEOUT` cycles, then the done+err cycle.
- All outputs registered; no combinational path from `WB_ACKi` or `cpu_req` to any output.

## Structure
- Shared package `ls1u_bus_pkg` holds:
  - state encoding (IDLE, CYCLE);
  - `WB_ERR_RDATA`=8'hFF;
  - default `TIMEOUT` constant.
- Natural sub-module: `wb_timeout_cnt` (clear, enable, `expired` flag, parameter `TIMEOUT`). Everything else stays in one FSM block.

## Test plan
- Always-ACK slave, write addr 0x000000 data 0x81 → CYC/STB/WE high exactly 1 cycle with ADR=0x000000, DAT=0x81; `cpu_done` next cycle, `cpu_err`=0.
- Interrupt controller as slave, after that write read addr 0x000000 → `cpu_rdata`=0x05 with `cpu_done`.
- Slave ACKs after 3 wait cycles, read returns 0x5A → CYC high 4 cycles, `cpu_rdata`=0x5A, no error; `cpu_req` held high → next access starts in done cycle.
- No slave (ACK stuck 0), TIMEOUT=15, read → CYC high exactly 15 cycles, then `cpu_done`=`cpu_err`=1, `cpu_rdata`=0xFF; ACK arriving on 15th cycle → no error.
- `rst` asserted low during third wait cycle → CYC/STB/busy go 0 asynchronously, no done pulse; after release, new write completes normally.
- TIMEOUT=0, ACK held low 100 cycles then high → single completion, `cpu_err`=0.
